// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module : mdu_ctrl_pkg
// Brief  : Op codes, FSM state encodings and op-decode helpers for mdu_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int         MDU_STATE_W = 2;
    localparam logic [1:0] MDU_IDLE    = 2'd0;
    localparam logic [1:0] MDU_CALC    = 2'd1;
    localparam logic [1:0] MDU_FIXUP   = 2'd2;

    function automatic logic mdu_is_iter(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// Module : mdu_step
// Brief  : One combinational iteration of shift-add multiply / restoring divide.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_step (
    input  logic [63:0] i_acc,
    input  logic [31:0] i_operand,
    input  logic        i_is_div,
    output logic [63:0] o_acc
);

    logic [32:0] w_addend;
    logic [32:0] w_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;
    logic [63:0] w_div_next;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    always_comb begin
        w_addend   = i_acc[0] ? {1'b0, i_operand} : 33'd0;
        w_sum      = {1'b0, i_acc[63:32]} + w_addend;
        w_mul_next = {w_sum, i_acc[31:1]};
    end

    // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at bit 0.
    always_comb begin
        w_rem_sh   = i_acc[63:31];
        w_trial    = w_rem_sh - {1'b0, i_operand};
        w_div_next = w_trial[32] ? {i_acc[62:0], 1'b0}
                                 : {w_trial[31:0], i_acc[30:0], 1'b1};
    end

    always_comb begin
        o_acc = i_is_div ? w_div_next : w_mul_next;
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module : mdu_ctrl
// Brief  : Multi-cycle MIPS32 multiply/divide controller owning HI/LO.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(ITERS - 1);

    logic [MDU_STATE_W-1:0] r_state;
    logic [MDU_STATE_W-1:0] w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [63:0]            r_acc;
    logic [31:0]            r_opnd;
    logic                   r_is_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_div0;
    logic [31:0]            r_hi;
    logic [31:0]            r_lo;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_signed;
    logic [31:0]            w_a_mag;
    logic [31:0]            w_b_mag;
    logic [63:0]            w_acc_next;
    logic [63:0]            w_prod;
    logic [31:0]            w_quo;
    logic [31:0]            w_rem;
    logic [31:0]            w_fix_hi;
    logic [31:0]            w_fix_lo;

    // A flush in IDLE drops any simultaneous issue, including MTHI/MTLO.
    always_comb begin
        w_accept = (r_state == MDU_IDLE) && start && !flush;
        w_signed = mdu_is_signed(op);
        w_a_mag  = (w_signed && a[31]) ? (32'd0 - a) : a;
        w_b_mag  = (w_signed && b[31]) ? (32'd0 - b) : b;
    end

    mdu_step u_step (
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_is_div  (r_is_div),
        .o_acc     (w_acc_next)
    );

    // Zero divisor leaves the remainder equal to |a|, so the remainder sign
    // fix-up restores the original a in HI; only LO needs forcing.
    always_comb begin
        w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
        w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        if (r_is_div) begin
            w_fix_hi = w_rem;
            w_fix_lo = r_div0 ? 32'hFFFF_FFFF : w_quo;
        end else begin
            w_fix_hi = w_prod[63:32];
            w_fix_lo = w_prod[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MDU_IDLE: begin
                if (w_accept && mdu_is_iter(op)) begin
                    w_next_state = MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (flush) begin
                    w_next_state = MDU_IDLE;
                end else if (r_cnt == c_last) begin
                    w_next_state = MDU_FIXUP;
                end
            end
            MDU_FIXUP: begin
                w_next_state = MDU_IDLE;
            end
            default: begin
                w_next_state = MDU_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state != MDU_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MDU_IDLE: begin
                    if (w_accept) begin
                        if (mdu_is_iter(op)) begin
                            r_acc    <= {32'd0, w_a_mag};
                            r_opnd   <= w_b_mag;
                            r_is_div <= mdu_is_div(op);
                            r_neg_q  <= w_signed && (a[31] ^ b[31]);
                            r_neg_r  <= w_signed && a[31];
                            r_div0   <= (b == 32'd0);
                            r_cnt    <= '0;
                        end else if (op == MDU_MTHI) begin
                            r_hi   <= a;
                            r_done <= 1'b1;
                        end else if (op == MDU_MTLO) begin
                            r_lo   <= a;
                            r_done <= 1'b1;
                        end
                    end
                end
                MDU_CALC: begin
                    if (!flush) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                MDU_FIXUP: begin
                    if (!flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module : tb_mdu_ctrl
// Brief  : Directed self-checking bench for mdu_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.WIDTH(32), .ITERS(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one op, then counts busy cycles until done (bounded). If poke>=0,
    // a stray MULTU 100*100 start is presented for one cycle at that point.
    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input int poke, output int bc, output logic gd);
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0;
        bc = 0;
        gd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == poke) begin
                start = 1'b1; op = MDU_MULTU; a = 32'd100; b = 32'd100;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                gd = 1'b1;
                break;
            end
            if (busy) bc++;
            tick();
        end
        start = 1'b0;
    endtask

    int   bc;
    logic gd;
    int   ndone;

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);

        do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, bc, gd);
        chk("multu_done", gd, 1);
        chk("multu_busy_cycles", bc, 33);
        chk("multu_busy_at_done", busy, 0);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        tick();
        chk("multu_done_pulse", done, 0);

        do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, -1, bc, gd);
        chk("mult_done", gd, 1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, -1, bc, gd);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        do_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, -1, bc, gd);
        chk("div_negb_lo", lo, 32'hFFFF_FFFD);
        chk("div_negb_hi", hi, 32'h0000_0001);

        do_op(MDU_DIVU, 32'd100, 32'd0, -1, bc, gd);
        chk("divu0_done", gd, 1);
        chk("divu0_busy_cycles", bc, 33);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'h0000_0064);

        do_op(MDU_DIV, 32'hFFFF_FFFB, 32'd0, -1, bc, gd);
        chk("div0_signed_lo", lo, 32'hFFFF_FFFF);
        chk("div0_signed_hi", hi, 32'hFFFF_FFFB);

        do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, bc, gd);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0000_0000);

        do_op(MDU_DIVU, 32'hFFFF_FFFF, 32'd10, -1, bc, gd);
        chk("divu_lo", lo, 32'h1999_9999);
        chk("divu_hi", hi, 32'h0000_0005);

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; op = MDU_MTHI; a = 32'h1234_5678;
        tick();
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_done", done, 1);
        chk("mthi_busy", busy, 0);
        op = MDU_MTLO; a = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);
        chk("mtlo_done", done, 1);
        chk("mtlo_busy", busy, 0);
        tick();
        chk("mtlo_done_pulse", done, 0);

        // flush and start together in IDLE: issue dropped
        start = 1'b1; flush = 1'b1; op = MDU_MTHI; a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_hi", hi, 32'h1234_5678);
        chk("idle_flush_done", done, 0);
        chk("idle_flush_busy", busy, 0);

        // unknown op ignored
        start = 1'b1; op = 3'd7; a = 32'hCAFE_0000;
        tick();
        start = 1'b0;
        chk("badop_busy", busy, 0);
        chk("badop_done", done, 0);

        // flush at CALC iteration 10
        start = 1'b1; op = MDU_MULTU; a = 32'd5; b = 32'd5;
        tick();
        start = 1'b0;
        chk("flush_busy_before", busy, 1);
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_after", busy, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("flush_no_done", ndone, 0);
        chk("flush_hi_kept", hi, 32'h1234_5678);
        chk("flush_lo_kept", lo, 32'h9ABC_DEF0);

        // stray start during busy is ignored
        do_op(MDU_MULTU, 32'd9, 32'd11, 5, bc, gd);
        chk("busy_start_done", gd, 1);
        chk("busy_start_cycles", bc, 33);
        chk("busy_start_lo", lo, 32'd99);
        chk("busy_start_hi", hi, 32'd0);
        tick();
        chk("busy_start_idle", busy, 0);

        // reset at iteration 20 of a DIV
        start = 1'b1; op = MDU_DIV; a = 32'd1000; b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);

        do_op(MDU_MULTU, 32'd6, 32'd7, -1, bc, gd);
        chk("post_rst_done", gd, 1);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
